operand_fifo_stage: RTL and testbench
=====================================

// Module: operand_fifo_stage
//
// PURPOSE
// - Parametrised successor to the two-operand input register: buffers {a,b} operand pairs
//   in a DEPTH-entry FIFO between the operand source and the ALU/compute stage.
// - Both sides use a valid/ready handshake; output is first-word-fall-through.
// - Provides occupancy, synchronous flush and a sticky protocol-violation flag on the input side.
//
// PARAMETERS
// - N      default 4   operand width in bits, >=1
// - DEPTH  default 4   FIFO entries; power of two, >=2
// - AW     derived     $clog2(DEPTH); local, not overridable
//
// PORTS
// - clk        in   1       single clock; all state updates on posedge
// - rst        in   1       synchronous, active-high reset
// - clr        in   1       synchronous flush, active-high
// - in_valid   in   1       source offers {a,b}
// - in_ready   out  1       stage accepts; push = in_valid & in_ready
// - a          in   N       operand A
// - b          in   N       operand B
// - out_valid  out  1       head entry present
// - out_ready  in   1       sink takes head; pop = out_valid & out_ready
// - new_a      out  N       head operand A
// - new_b      out  N       head operand B
// - count      out  AW+1    entries held, 0..DEPTH
// - proto_err  out  1       sticky input-protocol violation
//
// BEHAVIOUR
// - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, proto_err=0. Storage contents are not cleared.
//   Resulting outputs: out_valid=0, in_ready=1, new_a=new_b=0.
// - Priority: rst > clr > push/pop.
// - clr has the same effect as rst on pointers, count and proto_err. Any push or pop in that cycle is discarded.
// - in_ready = (count != DEPTH); out_valid = (count != 0). Both derive from registered state only.
//   Neither depends combinationally on in_valid or out_ready.
// - new_a/new_b = storage[rd_ptr] when out_valid=1, else forced to 0.
// - Push writes {a,b} to storage[wr_ptr]; wr_ptr increments mod DEPTH (natural wrap at AW bits).
// - Pop increments rd_ptr mod DEPTH.
// - Count update:
//   - push only: count+1
//   - pop only: count-1
//   - push and pop together: count unchanged, both pointers advance
// - Latency:
//   - push into empty FIFO: out_valid=1 and data on new_a/new_b in the next cycle
//   - pop from full FIFO: in_ready=1 in the next cycle
// - Full: in_ready=0, so a push is never accepted. This holds even if a pop occurs in the same cycle (no pass-through).
// - Empty: out_valid=0, so out_ready is ignored and no pop occurs.
// - Protocol check: a stall is a cycle with in_valid=1 and in_ready=0.
//   - If the next cycle has in_valid=0, or a/b differ from the stalled values, proto_err sets to 1 at that edge.
//   - proto_err stays 1 until rst or clr.
//   - The stalled values are captured in a shadow register each stall cycle.
//   - The FIFO operates normally regardless of proto_err.
// - Mid-operation reset/flush: all queued entries are lost in the same edge; no partial pop.
//
// TESTING
// - Reset, then idle -> out_valid=0, in_ready=1, count=0, new_a=new_b=0, proto_err=0.
// - Push (a=3,b=5) with out_ready=0 -> next cycle out_valid=1, new_a=3, new_b=5, count=1.
// - DEPTH=4: push 1..4 with out_ready=0 -> count=4, in_ready=0.
//   Then offer a 5th push with pop asserted -> 5th not accepted, count=3.
//   Pops then return 1,2,3,4 in order.
// - Steady stream: in_valid=out_ready=1 for 10 cycles -> count stays 1 after the first cycle.
//   Outputs match the inputs delayed by 1; pointers wrap cleanly past DEPTH.
// - Fill to full, hold in_valid=1 with a=7, then change a to 8 while stalled -> proto_err=1 next edge.
//   Then assert clr -> proto_err=0, count=0.
// - count=2 with rst and push asserted in the same cycle -> next cycle count=0, out_valid=0, new_a=new_b=0.

Source files
------------

// File: rtl/operand_fifo_stage.sv
// Operand-pair FIFO between the operand source and the compute stage.
// Valid/ready on both sides, first-word-fall-through output, sticky input-protocol flag.
module operand_fifo_stage #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             a,
    input  logic [N-1:0]             b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             new_a,
    output logic [N-1:0]             new_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [2*N-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          proto_err_q, proto_err_d;
    logic          stall_q, stall_d;
    logic [N-1:0]  shadow_a_q, shadow_a_d;
    logic [N-1:0]  shadow_b_q, shadow_b_d;

    logic          push;
    logic          pop;
    logic          stall;
    logic          proto_viol;
    logic [2*N-1:0] head;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign proto_err = proto_err_q;

    assign push  = in_valid & in_ready;
    assign pop   = out_valid & out_ready;
    assign stall = in_valid & ~in_ready;

    // A stalled offer must be held unchanged until it is accepted.
    assign proto_viol = stall_q & (~in_valid | (a != shadow_a_q) | (b != shadow_b_q));

    assign head  = mem_q[rd_ptr_q];
    assign new_a = out_valid ? head[2*N-1:N] : '0;
    assign new_b = out_valid ? head[N-1:0]   : '0;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        proto_err_d = proto_err_q;
        stall_d     = stall_q;
        shadow_a_d  = shadow_a_q;
        shadow_b_d  = shadow_b_q;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            proto_err_d = 1'b0;
            stall_d     = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (proto_viol) begin
                proto_err_d = 1'b1;
            end
            stall_d = stall;
            if (stall) begin
                shadow_a_d = a;
                shadow_b_d = b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
            stall_q     <= 1'b0;
            shadow_a_q  <= '0;
            shadow_b_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
            stall_q     <= stall_d;
            shadow_a_q  <= shadow_a_d;
            shadow_b_q  <= shadow_b_d;
        end
    end

    // Storage is deliberately left uncleared; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && !clr && push) begin
            mem_q[wr_ptr_q] <= {a, b};
        end
    end

endmodule

// File: tb/tb_operand_fifo_stage.sv
// Self-checking bench for operand_fifo_stage: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_operand_fifo_stage;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  new_a;
    logic [N-1:0]  new_b;
    logic [AW:0]   count;
    logic          proto_err;

    int checks = 0;
    int errors = 0;
    bit checking_en = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
    } pair_t;

    pair_t        model_q[$];
    bit           model_perr = 0;
    bit           model_stall = 0;
    logic [N-1:0] model_sa = '0;
    logic [N-1:0] model_sb = '0;

    operand_fifo_stage #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .new_a     (new_a),
        .new_b     (new_b),
        .count     (count),
        .proto_err (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pairs plus the held-offer rule.
    always @(posedge clk) begin
        bit m_in_ready;
        bit m_out_valid;
        bit do_push;
        bit do_pop;
        if (rst || clr) begin
            model_q.delete();
            model_perr  = 0;
            model_stall = 0;
        end else begin
            m_in_ready  = (model_q.size() < DEPTH);
            m_out_valid = (model_q.size() > 0);
            do_push = in_valid && m_in_ready;
            do_pop  = m_out_valid && out_ready;
            if (model_stall && (!in_valid || a != model_sa || b != model_sb))
                model_perr = 1;
            model_stall = in_valid && !m_in_ready;
            if (model_stall) begin
                model_sa = a;
                model_sb = b;
            end
            if (do_pop)
                void'(model_q.pop_front());
            if (do_push)
                model_q.push_back('{a: a, b: b});
        end
    end

    // Compare process: outputs checked against the model every cycle.
    always @(negedge clk) begin
        if (checking_en) begin
            check("model_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            check("model_in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
            check("model_count",     32'(count),     32'(model_q.size()));
            check("model_new_a",     32'(new_a),     model_q.size() != 0 ? 32'(model_q[0].a) : 32'd0);
            check("model_new_b",     32'(new_b),     model_q.size() != 0 ? 32'(model_q[0].b) : 32'd0);
            check("model_proto_err", 32'(proto_err), 32'(model_perr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bias;
        rst = 1; clr = 0; in_valid = 0; out_ready = 0; a = '0; b = '0;
        tick();
        tick();
        rst = 0;
        checking_en = 1;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_count",     32'(count),     0);
        check("rst_new_a",     32'(new_a),     0);
        check("rst_new_b",     32'(new_b),     0);
        check("rst_proto_err", 32'(proto_err), 0);

        // Single push falls through on the next cycle
        in_valid = 1; a = 3; b = 5; out_ready = 0;
        tick();
        in_valid = 0;
        check("one_out_valid", 32'(out_valid), 1);
        check("one_new_a",     32'(new_a),     3);
        check("one_new_b",     32'(new_b),     5);
        check("one_count",     32'(count),     1);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("one_drained", 32'(count), 0);

        // Fill to full, then a push offered alongside a pop is refused
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; a = N'(i); b = N'(i + 8);
            tick();
        end
        check("full_count",    32'(count),    4);
        check("full_in_ready", 32'(in_ready), 0);
        a = 5; b = 13; out_ready = 1;
        tick();
        check("nopass_count", 32'(count), 3);
        check("nopass_head",  32'(new_a), 2);
        in_valid = 0;
        for (int k = 2; k <= 4; k++) begin
            check("order_a", 32'(new_a), 32'(k));
            check("order_b", 32'(new_b), 32'(k + 8));
            tick();
        end
        out_ready = 0;
        check("order_empty", 32'(count), 0);
        check("withdraw_perr", 32'(proto_err), 1);
        clr = 1;
        tick();
        clr = 0;
        check("clr1_perr", 32'(proto_err), 0);

        // Steady stream with pointer wrap
        in_valid = 1; out_ready = 1;
        for (int j = 0; j < 10; j++) begin
            a = N'(j + 1); b = N'(15 - j);
            tick();
            check("stream_count", 32'(count), 1);
            check("stream_new_a", 32'(new_a), 32'((j + 1) % 16));
        end
        in_valid = 0;
        tick();
        out_ready = 0;
        check("stream_drain", 32'(count), 0);

        // Changing a stalled offer raises the sticky flag; clr clears it
        in_valid = 1; a = 7; b = 1;
        for (int i = 0; i < 4; i++) tick();
        tick();
        check("stall_no_err", 32'(proto_err), 0);
        a = 8;
        tick();
        check("stall_err", 32'(proto_err), 1);
        clr = 1; in_valid = 0;
        tick();
        clr = 0;
        check("clr_perr",  32'(proto_err), 0);
        check("clr_count", 32'(count),     0);

        // Reset beats a simultaneous push
        in_valid = 1; a = 2; b = 4;
        tick();
        tick();
        check("pre_rst_count", 32'(count), 2);
        rst = 1; a = 9;
        tick();
        rst = 0; in_valid = 0;
        check("rstpush_count",     32'(count),     0);
        check("rstpush_out_valid", 32'(out_valid), 0);
        check("rstpush_new_a",     32'(new_a),     0);
        check("rstpush_new_b",     32'(new_b),     0);

        // Randomized traffic with varying drain bias
        bias = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) bias = (i / 200) % 3 == 0 ? 20 : ((i / 200) % 3 == 1 ? 80 : 50);
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 59) == 0);
            if (!(in_valid && !in_ready) || $urandom_range(0, 7) == 0) begin
                in_valid = ($urandom_range(0, 2) != 0);
                a = N'($urandom);
                b = N'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < bias);
            tick();
        end
        rst = 0; clr = 0; in_valid = 0; out_ready = 0;
        tick();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
